// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller.
// Opcodes, FSM states and instruction field positions.
package alu_pkg;

  localparam logic [2:0] OP_SUB = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;
  localparam logic [2:0] OP_ROL = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  localparam int SEL_MSB = 8;
  localparam int SEL_LSB = 6;
  localparam int DST_MSB = 5;
  localparam int DST_LSB = 4;
  localparam int SRS_MSB = 3;
  localparam int SRS_LSB = 2;
  localparam int SRT_MSB = 1;
  localparam int SRT_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// 4x4 register file, two async reads, two write ports.
// Write-back port wins over the external port on an address collision.
module alu_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_ra_addr,
  output logic [3:0] o_ra_data,
  input  logic [1:0] i_rb_addr,
  output logic [3:0] o_rb_data,
  input  logic       i_wb_en,
  input  logic [1:0] i_wb_addr,
  input  logic [3:0] i_wb_data,
  input  logic       i_ext_en,
  input  logic [1:0] i_ext_addr,
  input  logic [3:0] i_ext_data
);

  logic [3:0] r_mem [4];

  assign o_ra_data = r_mem[i_ra_addr];
  assign o_rb_data = r_mem[i_rb_addr];

  // Later NBA to the same entry takes effect, giving write-back priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 4'd0;
    end else begin
      if (i_ext_en) r_mem[i_ext_addr] <= i_ext_data;
      if (i_wb_en)  r_mem[i_wb_addr]  <= i_wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back sequencer for the combinational 4-bit ALU.
// IDLE -> ISSUE (operands registered) -> EXEC (result written back).
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int OP_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [8:0]          instr,
  output logic                instr_ready,
  input  logic                wr_en,
  input  logic [1:0]          wr_addr,
  input  logic [3:0]          wr_data,
  output logic [3:0]          alu_rs,
  output logic [3:0]          alu_rt,
  output logic [2:0]          alu_sel,
  input  logic [3:0]          alu_rd,
  output logic                res_valid,
  output logic [3:0]          res_data,
  output logic [1:0]          res_addr,
  output logic [OP_CNT_W-1:0] op_count
);

  state_t     r_state;
  state_t     w_next;
  logic [8:0] r_instr;
  logic       w_accept;
  logic       w_issue;
  logic       w_exec;
  logic [3:0] w_rs_data;
  logic [3:0] w_rt_data;

  assign instr_ready = (r_state == S_IDLE);

  alu_regfile u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ra_addr  (r_instr[SRS_MSB:SRS_LSB]),
    .o_ra_data  (w_rs_data),
    .i_rb_addr  (r_instr[SRT_MSB:SRT_LSB]),
    .o_rb_data  (w_rt_data),
    .i_wb_en    (w_exec),
    .i_wb_addr  (r_instr[DST_MSB:DST_LSB]),
    .i_wb_data  (alu_rd),
    .i_ext_en   (wr_en),
    .i_ext_addr (wr_addr),
    .i_ext_data (wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    w_exec   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        w_next  = S_EXEC;
      end
      S_EXEC: begin
        w_exec = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr   <= '0;
      alu_rs    <= '0;
      alu_rt    <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_addr  <= '0;
      op_count  <= '0;
    end else begin
      res_valid <= w_exec;
      if (w_accept) r_instr <= instr;
      if (w_issue) begin
        alu_rs  <= w_rs_data;
        alu_rt  <= w_rt_data;
        alu_sel <= r_instr[SEL_MSB:SEL_LSB];
      end
      if (w_exec) begin
        res_data <= alu_rd;
        res_addr <= r_instr[DST_MSB:DST_LSB];
        if (op_count != '1) op_count <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential front end for the combinational `Decode_And_Execute` 4-bit ALU. Accepts encoded instructions over a valid/ready handshake, reads operands from a 4-entry × 4-bit register file, drives the ALU's `rs`/`rt`/`sel` ports, captures `rd`, and writes the result back. It is the initiator side of the ALU interface and replaces bench-driven operands in the lab top level.

## Interface
- `OP_CNT_W`, default 8: width of the completed-operation counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_valid`  in  1  instruction word present.
- `instr`  in  9  {sel[8:6], dst[5:4], src_s[3:2], src_t[1:0]}.
- `instr_ready`  out  1  high when the block can accept an instruction.
- `wr_en`  in  1  external register write request.
- `wr_addr`  in  2  external write address.
- `wr_data`  in  4  external write data.
- `alu_rs`  out  4  operand to ALU `rs`.
- `alu_rt`  out  4  operand to ALU `rt`.
- `alu_sel`  out  3  opcode to ALU `sel`.
- `alu_rd`  in  4  ALU result, combinational from `alu_rs`/`alu_rt`/`alu_sel`.
- `res_valid`  out  1  one-cycle pulse: write-back done.
- `res_data`  out  4  written-back value, held until next write-back.
- `res_addr`  out  2  destination of that write-back.
- `op_count`  out  OP_CNT_W  completed instructions, saturating.

## Operation
- ALU opcodes: 000 rs−rt, 001 rs+rt, 010 rs|rt, 011 rs&rt, 100 rotate-right rt by 1, 101 rotate-left rs by 1, 110 4'b1010+(rs<rt), 111 4'b1110+(rs==rt). All arithmetic is modulo 16, unsigned.
- FSM states:
  - IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` and go to ISSUE.
  - ISSUE: register `alu_rs`=R[src_s], `alu_rt`=R[src_t], `alu_sel`=sel. Go to EXEC.
  - EXEC: ALU inputs stable. Sample `alu_rd` into R[dst], `res_data`, `res_addr`. Pulse `res_valid`, increment `op_count`. Go to IDLE.
- `instr_ready` = (state==IDLE), combinational from state only. No dependency on `instr_valid`.
- One instruction in flight; no forwarding needed. Operands are read in ISSUE, so an external write completing before ISSUE is visible.
- External write takes effect on any cycle `wr_en`=1.
  - Same-edge collision with the EXEC write-back to the same address: write-back wins, external write dropped.
  - Different addresses: both writes occur.
- `alu_*` outputs hold their last values outside ISSUE/EXEC.
- `op_count` saturates at 2^OP_CNT_W−1 and does not wrap.
- Reset values: all R = 0; `alu_rs`/`alu_rt`=0; `alu_sel`=000; `res_valid`=0; `res_data`=0; `res_addr`=0; `op_count`=0; state=IDLE.
- Reset asserted mid-operation aborts it: no write-back, no `res_valid`, state returns to IDLE.

## Timing
- Handshake completes on the edge where `instr_valid`&&`instr_ready`. Accept at edge N → ALU ports valid after edge N+1 → write-back and `res_valid` after edge N+2.
- Throughput: one instruction per 3 cycles. `instr_ready` next high after edge N+2.
- `res_valid` is high for exactly one cycle per instruction.
- A `wr_en` write at edge N+1 (ISSUE edge) is not seen by the current instruction's operands.
- `alu_rd` must settle within one cycle of `alu_*` changing.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `OP_SUB`…`OP_EQ`;
  - state encodings `S_IDLE`/`S_ISSUE`/`S_EXEC`;
  - instruction field slice constants.
- Sub-module `alu_regfile`: 4×4, two async read ports, two write ports with the collision-priority rule above.
- The top level instantiates `alu_regfile` plus the FSM. The bench connects the real `Decode_And_Execute` to the `alu_*` ports.

## Test plan
- Reset, then load R0=3, R1=5 via `wr_en`. Issue add (001, dst=2, s=0, t=1) → `alu_rs`=3, `alu_rt`=5 one cycle after accept; `res_valid` with `res_data`=8, R2=8, `op_count`=1.
- Issue sub 3−5, then lt (110) and eq (111) on the same operands → 14, 11, 14. `instr_ready` low for exactly 2 cycles after each accept.
- R0=9: rotate-left (101, s=0) → 3. R1=5: rotate-right (100, t=1) → 10.
- During EXEC of an add with dst=2, assert `wr_en` to addr 2 with data 7 → R2 = add result. Repeat with addr 3 → R3=7 and R2 = result.
- Assert `rst_n` low during EXEC → no `res_valid`, all registers 0, `instr_ready`=1 after release.
- Run 260 instructions with OP_CNT_W=8 → `op_count` stops at 255.
